reg_access_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one W-bit flip-flop register between N requesters. Each requester issues a load, set, clear or toggle command through a req/ack handshake. The arbiter serialises the commands, applies exactly one per transaction to the register, and returns a one-cycle ack. It sits in front of the set/reset flop bank as its only write path, so concurrent masters never drive `d`/`set`/`rst` directly.

---
 rtl/reg_access_arbiter.sv | 136 +++++++++++++
 tb/tb_reg_access_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter that serialises load/set/clear/toggle commands
// from N requesters onto one shared W-bit register.
module reg_access_arbiter #(
  parameter int         N       = 4,
  parameter int         W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [2*N-1:0] op,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   ack,
  output logic           busy,
  output logic [W-1:0]   q
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t        state, state_d;
  logic [IW-1:0] ptr, ptr_d;
  logic [IW-1:0] idx, idx_d;
  logic [1:0]    op_l, op_d;
  logic [W-1:0]  data_l, data_d;
  logic [N-1:0]  gnt_d, ack_d;
  logic          busy_d;
  logic [W-1:0]  q_d;

  logic          found;
  logic [IW-1:0] pick;
  logic [IW:0]   c;
  logic [1:0]    sel_op;
  logic [W-1:0]  sel_data;
  logic [IW-1:0] nxt_ptr;

  // Wrap-around search upward from ptr; c never reaches 2N so one subtract suffices
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    c     = '0;
    for (int k = 0; k < N; k++) begin
      c = {1'b0, ptr} + (IW+1)'(k);
      if (c >= (IW+1)'(N)) c = c - (IW+1)'(N);
      if (!found && req[c[IW-1:0]]) begin
        found = 1'b1;
        pick  = c[IW-1:0];
      end
    end
  end

  always_comb begin
    sel_op   = '0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (pick == IW'(i)) begin
        sel_op   = op[2*i +: 2];
        sel_data = wdata[W*i +: W];
      end
    end
  end

  assign nxt_ptr = (idx == IW'(N-1)) ? '0 : idx + 1'b1;

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    idx_d   = idx;
    op_d    = op_l;
    data_d  = data_l;
    gnt_d   = gnt;
    ack_d   = '0;
    busy_d  = busy;
    q_d     = q;
    unique case (state)
      IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (found) begin
          idx_d   = pick;
          op_d    = sel_op;
          data_d  = sel_data;
          gnt_d   = N'(1) << pick;
          busy_d  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        unique case (op_l)
          2'b00:   q_d = data_l;
          2'b01:   q_d = '1;
          2'b10:   q_d = '0;
          default: q_d = ~q;
        endcase
        state_d = DONE;
      end
      DONE: begin
        ack_d   = gnt;
        ptr_d   = nxt_ptr;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      idx    <= '0;
      op_l   <= '0;
      data_l <= '0;
      gnt    <= '0;
      ack    <= '0;
      busy   <= 1'b0;
      q      <= RST_VAL;
    end else begin
      state  <= state_d;
      ptr    <= ptr_d;
      idx    <= idx_d;
      op_l   <= op_d;
      data_l <= data_d;
      gnt    <= gnt_d;
      ack    <= ack_d;
      busy   <= busy_d;
      q      <= q_d;
    end
  end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed self-checking bench for reg_access_arbiter (N=4, W=8).
module tb_reg_access_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [2*N-1:0] op;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic           busy;
  logic [W-1:0]   q;

  int npass = 0;
  int ntot  = 0;

  reg_access_arbiter #(
    .N(N),
    .W(W),
    .RST_VAL(8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .op(op),
    .wdata(wdata),
    .gnt(gnt),
    .ack(ack),
    .busy(busy),
    .q(q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input int r, input logic [1:0] o,
                     input logic [7:0] d, input logic [7:0] qexp);
    req = '0;
    req[r] = 1'b1;
    op[2*r +: 2] = o;
    wdata[W*r +: W] = d;
    step();
    check("txn_gnt", 32'(gnt), 32'(1 << r));
    req = '0;
    step();
    check("txn_q", 32'(q), 32'(qexp));
    check("txn_noack", 32'(ack), 32'h0);
    step();
    check("txn_ack", 32'(ack), 32'(1 << r));
    step();
    check("txn_ack_clr", 32'(ack), 32'h0);
    check("txn_idle", 32'(busy), 32'h0);
  endtask

  int order [6] = '{0, 1, 3, 0, 1, 3};
  logic [7:0] rr_data [4] = '{8'h10, 8'h21, 8'h32, 8'h43};

  initial begin
    rst   = 1'b1;
    req   = 4'b1111;
    op    = '0;
    wdata = '0;

    // Reset held with all requests pending
    @(posedge clk);
    step();
    check("rst_q", 32'(q), 32'h00);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    step();
    check("rel_gnt", 32'(gnt), 32'h1);
    check("rel_busy", 32'(busy), 32'h1);
    req = '0;
    step();
    step();
    check("rel_ack", 32'(ack), 32'h1);
    step();
    check("rel_idle_gnt", 32'(gnt), 32'h0);

    // Single load from requester 2
    req = 4'b0100;
    op[5:4] = 2'b00;
    wdata[23:16] = 8'hA5;
    step();
    check("ld_gnt", 32'(gnt), 32'h4);
    check("ld_busy", 32'(busy), 32'h1);
    check("ld_q_hold", 32'(q), 32'h00);
    req = '0;
    step();
    check("ld_q", 32'(q), 32'hA5);
    check("ld_ack0", 32'(ack), 32'h0);
    step();
    check("ld_ack", 32'(ack), 32'h4);
    check("ld_gnt_held", 32'(gnt), 32'h4);
    step();
    check("ld_ack_clr", 32'(ack), 32'h0);
    check("ld_busy_clr", 32'(busy), 32'h0);
    check("ld_q_keep", 32'(q), 32'hA5);

    // Op sweep on requester 1
    txn(1, 2'b00, 8'h3C, 8'h3C);
    txn(1, 2'b11, 8'h00, 8'hC3);
    txn(1, 2'b01, 8'h00, 8'hFF);
    txn(1, 2'b10, 8'h00, 8'h00);

    // Reset pointer, then hold req=1011
    rst = 1'b1;
    #2;
    rst = 1'b0;
    op = '0;
    for (int i = 0; i < N; i++) wdata[W*i +: W] = rr_data[i];
    req = 4'b1011;
    for (int g = 0; g < 6; g++) begin
      step();
      check("rr_gnt", 32'(gnt), 32'(1 << order[g]));
      step();
      check("rr_q", 32'(q), 32'(rr_data[order[g]]));
      step();
      check("rr_ack", 32'(ack), 32'(1 << order[g]));
    end
    req = '0;
    step();
    check("rr_end_gnt", 32'(gnt), 32'h0);
    check("rr_end_busy", 32'(busy), 32'h0);

    // Command latched at grant; later changes and dropped req ignored
    req = 4'b0010;
    op[3:2] = 2'b00;
    wdata[15:8] = 8'h11;
    step();
    check("lat_gnt", 32'(gnt), 32'h2);
    wdata[15:8] = 8'h99;
    op[3:2] = 2'b01;
    req = '0;
    step();
    check("lat_q", 32'(q), 32'h11);
    step();
    check("lat_ack", 32'(ack), 32'h2);
    step();

    // Reset pulse during EXEC aborts a load of 8'h77
    req = 4'b0001;
    op[1:0] = 2'b00;
    wdata[7:0] = 8'h77;
    step();
    check("mid_gnt", 32'(gnt), 32'h1);
    req = 4'b1010;
    rst = 1'b1;
    #2;
    check("mid_rst_q", 32'(q), 32'h00);
    check("mid_rst_gnt", 32'(gnt), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    step();
    check("mid_q_kept", 32'(q), 32'h00);
    check("mid_noack", 32'(ack), 32'h0);
    check("mid_next_gnt", 32'(gnt), 32'h2);
    req = '0;
    step();
    step();
    check("mid_ack", 32'(ack), 32'h2);
    step();
    check("mid_final_busy", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
